// File: rtl/pc_sequencer_if.sv
// Instruction-memory read bus between the sequencer (master) and instruction memory (slave).
// The read completes in the cycle mem_ack is high; instr is valid in that same cycle.
interface pc_sequencer_if #(
   parameter int unsigned DWIDTH = 16
) ();
   logic              mem_req;
   logic              mem_ack;
   logic [DWIDTH-1:0] instr;

   modport master (
      output mem_req,
      input  mem_ack,
      input  instr
   );

   modport slave (
      input  mem_req,
      output mem_ack,
      output instr
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller: fetches instruction words, decodes them and drives
// PC update and ALU strobes. Every output is a flop loaded from the next-state decode.
module pc_sequencer #(
   parameter int unsigned DWIDTH      = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              zero_flag,
   pc_sequencer_if.master    mem,
   output logic [DWIDTH-1:0] ir_out,
   output logic              pc_en,
   output logic [1:0]        pc_ctrl,
   output logic [7:0]        offset_addr,
   output logic              alu_en,
   output logic [2:0]        alu_op,
   output logic              busy,
   output logic              halted,
   output logic [1:0]        err_code
);
   localparam int unsigned CNT_W = 8;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_JMP  = 4'h2;
   localparam logic [3:0] OP_JZ   = 4'h3;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_LOAD = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DWIDTH-1:0]  ir_d;
   logic [1:0]         err_d;
   logic               mem_req_q, mem_req_d;
   logic               pc_en_d, alu_en_d, busy_d, halted_d;
   logic [1:0]         pc_ctrl_d;
   logic [3:0]         opcode;

   assign opcode      = ir_out[DWIDTH-1 -: 4];
   assign offset_addr = ir_out[7:0];
   assign alu_op      = ir_out[10:8];
   assign mem.mem_req = mem_req_q;

   // Next state plus next value of every registered output.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ir_d      = ir_out;
      err_d     = err_code;
      pc_en_d   = 1'b0;
      pc_ctrl_d = PC_HOLD;
      alu_en_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            // An ack in the final allowed cycle still completes the fetch.
            if (mem.mem_ack) begin
               ir_d    = mem.instr;
               cnt_d   = '0;
               state_d = S_DECODE;
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               cnt_d   = '0;
               err_d   = ERR_TIMEOUT;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            // zero_flag is folded into pc_ctrl here, so it is captured on this edge.
            case (opcode)
               OP_NOP, OP_ALU: begin
                  pc_en_d   = 1'b1;
                  pc_ctrl_d = PC_INC;
                  alu_en_d  = (opcode == OP_ALU);
                  state_d   = S_EXEC;
               end
               OP_JMP: begin
                  pc_en_d   = 1'b1;
                  pc_ctrl_d = PC_LOAD;
                  state_d   = S_EXEC;
               end
               OP_JZ: begin
                  pc_en_d   = 1'b1;
                  pc_ctrl_d = zero_flag ? PC_LOAD : PC_INC;
                  state_d   = S_EXEC;
               end
               OP_HALT: state_d = S_HALT;
               default: begin
                  err_d   = ERR_ILLEGAL;
                  state_d = S_HALT;
               end
            endcase
         end
         S_EXEC:  state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      mem_req_d = (state_d == S_FETCH);
      busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
      halted_d  = (state_d == S_HALT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ir_out    <= '0;
         err_code  <= ERR_NONE;
         mem_req_q <= 1'b0;
         pc_en     <= 1'b0;
         pc_ctrl   <= PC_HOLD;
         alu_en    <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ir_out    <= ir_d;
         err_code  <= err_d;
         mem_req_q <= mem_req_d;
         pc_en     <= pc_en_d;
         pc_ctrl   <= pc_ctrl_d;
         alu_en    <= alu_en_d;
         busy      <= busy_d;
         halted    <= halted_d;
      end
   end
endmodule
